// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: IRQ lines, control_unit handshake and d_bus signals of the interrupt controller.
interface interrupt_controller_if #(parameter int N_IRQ = 8);
  logic [N_IRQ-1:0] irq;
  logic             io_interrupt;
  logic             io_store_retaddr;
  logic             io_push_int_addr;
  logic             io_push_retaddr;
  logic             io_push_ints;
  logic             io_write;
  logic [3:0]       io_addr;
  logic [15:0]      d_in;
  logic [15:0]      d_out;
  logic             d_oe;
  logic [15:0]      vec_addr;
  modport master (
    output irq, io_store_retaddr, io_push_int_addr, io_push_retaddr, io_push_ints,
           io_write, io_addr, d_in,
    input  io_interrupt, d_out, d_oe, vec_addr
  );
  modport slave (
    input  irq, io_store_retaddr, io_push_int_addr, io_push_retaddr, io_push_ints,
           io_write, io_addr, d_in,
    output io_interrupt, d_out, d_oe, vec_addr
  );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered IRQ collector with enable mask and interrupt-entry handshake.
// Define IRQ_SYNC_EN to pass irq through a 2-flop synchroniser for asynchronous sources.
module interrupt_controller #(
  parameter int          N_IRQ       = 8,
  parameter logic [15:0] VEC_BASE    = 16'h0010,
  parameter logic [3:0]  INT_IO_ADDR = 4'hF
) (
  input logic clk,
  input logic rst,
  interrupt_controller_if.slave bus
);
  typedef enum logic {IDLE, SERVICE} state_t;
  state_t           state, state_d;
  logic [N_IRQ-1:0] pending, enable, irq_s, irq_q, act, clr, rise;
  logic [15:0]      retaddr;
  logic [3:0]       idx, low;
  logic             take;
`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.irq;
      sync2 <= sync1;
    end
  assign irq_s = sync2;
`else
  assign irq_s = bus.irq;
`endif
  always_comb begin
    act = pending & enable;
    low = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (act[i]) low = 4'(i);
    rise = irq_s & ~irq_q;
    take = state == IDLE && bus.io_store_retaddr;
    clr = take ? act & (N_IRQ'(1) << low) : '0;
    state_d = take ? SERVICE : (state == SERVICE && bus.io_push_retaddr) ? IDLE : state;
    bus.io_interrupt = state == IDLE && |act;
    bus.d_oe = bus.io_push_retaddr | bus.io_push_ints;
    bus.d_out = bus.io_push_retaddr ? retaddr : bus.io_push_ints ? 16'(pending) : '0;
    // In IDLE the address looks ahead to the line about to be taken.
    bus.vec_addr = VEC_BASE + {12'b0, (state == IDLE && (bus.io_store_retaddr || bus.io_push_int_addr)) ? low : idx};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      enable  <= '1;
      retaddr <= '0;
      idx     <= '0;
      irq_q   <= '0;
    end else begin
      state   <= state_d;
      irq_q   <= irq_s;
      pending <= (pending & ~clr) | rise;
      if (take) begin
        retaddr <= bus.d_in;
        idx     <= low;
      end
      if (bus.io_write && bus.io_addr == INT_IO_ADDR) enable <= bus.d_in[N_IRQ-1:0];
    end
endmodule
